// File: rtl/r5fp_mul_wb.sv
// Writeback buffer for FP multiply results: canonicalises NaNs, maps status to RISC-V flags, sticky fflags.
// Latency 1 cycle push->out_valid; 2-entry FIFO, in_ready low when full (no in->out combinational path).
module r5fp_mul_wb #(
    parameter int EXP_W = 8,
    parameter int SIG_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+SIG_W:0]   in_z,
    input  logic [7:0]             in_status,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+SIG_W:0]   out_z,
    output logic [4:0]             out_flags,
    output logic [4:0]             fflags,
    input  logic                   fflags_clr,
    output logic [1:0]             count
);

    localparam logic [EXP_W+SIG_W:0] CANON_NAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(SIG_W-1){1'b0}}};

    logic [EXP_W+SIG_W:0] mem_z [2];
    logic [4:0]           mem_f [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic                 push;
    logic                 pop;
    logic                 is_nan;
    logic [EXP_W+SIG_W:0] push_z;
    logic [4:0]           push_flags;
    logic                 unused_status;

    assign unused_status = ^{in_status[7:6], in_status[1:0]};

    // Reset gating keeps in_ready low while held in reset; otherwise purely from registered count.
    assign in_ready  = reset && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_z     = mem_z[rd_ptr];
    assign out_flags = mem_f[rd_ptr];

    assign is_nan     = (&in_z[EXP_W+SIG_W-1:SIG_W]) && (|in_z[SIG_W-1:0]);
    assign push_z     = is_nan ? CANON_NAN : in_z;
    // {NV, DZ, OF, UF, NX}; underflow only counts when the tiny result is also inexact.
    assign push_flags = {in_status[2], 1'b0, in_status[4], in_status[3] & in_status[5], in_status[5]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_z[0] <= '0;
            mem_z[1] <= '0;
            mem_f[0] <= '0;
            mem_f[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            fflags   <= 5'd0;
        end else begin
            if (push) begin
                mem_z[wr_ptr] <= push_z;
                mem_f[wr_ptr] <= push_flags;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            // Flags retire with the entry, so a clear in the same cycle keeps the popped flags.
            if (pop) begin
                fflags <= (fflags_clr ? 5'd0 : fflags) | out_flags;
            end else if (fflags_clr) begin
                fflags <= 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_r5fp_mul_wb.sv
// Scoreboarded bench for r5fp_mul_wb: directed vectors plus a long streaming run with random backpressure.
module tb_r5fp_mul_wb;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_z;
    logic [7:0]  in_status;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic [4:0]  out_flags;
    logic [4:0]  fflags;
    logic        fflags_clr;
    logic [1:0]  count;

    int n_vec = 0;
    int n_err = 0;

    logic [36:0] sb[$];
    logic [4:0]  acc_ff;
    logic        held_v;
    logic [36:0] held_d;
    logic        prod_done;

    r5fp_mul_wb #(.EXP_W(8), .SIG_W(23)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_z       (in_z),
        .in_status  (in_status),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .out_flags  (out_flags),
        .fflags     (fflags),
        .fflags_clr (fflags_clr),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [36:0] model(input logic [31:0] z, input logic [7:0] s);
        logic [31:0] zz;
        zz = z;
        if (z[30:23] == 8'hFF && z[22:0] != 23'd0) zz = 32'h7FC00000;
        return {zz, s[2], 1'b0, s[4], s[3] & s[5], s[5]};
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [31:0] z, input logic [7:0] st, input logic [36:0] exp);
        logic ok;
        ok = 1'b0;
        in_valid  = 1'b1;
        in_z      = z;
        in_status = st;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", {63'd0, ok}, 64'd1);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        @(posedge clk);
        @(negedge clk);
        chk("drain_count", count, 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid) chk("hold_stable", {out_z, out_flags}, held_d);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", {out_z, out_flags}, 64'hDEAD_0000_0000_0000);
                end else begin
                    logic [36:0] e;
                    e = sb.pop_front();
                    chk("out_entry", {out_z, out_flags}, e);
                    acc_ff = acc_ff | e[4:0];
                end
            end
            held_v = out_valid && !out_ready;
            held_d = {out_z, out_flags};
        end
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_z = '0; in_status = '0;
        out_ready = 1'b0; fflags_clr = 1'b0; acc_ff = '0; held_v = 1'b0; held_d = '0;
        prod_done = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_fflags", fflags, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_z", out_z, 0);
        chk("rel_out_flags", out_flags, 0);

        // Basic pass-through and NaN canonicalisation
        @(posedge clk); #1 out_ready = 1'b1;
        send(32'h40400000, 8'h00, {32'h40400000, 5'b00000});
        wait_drain();
        @(posedge clk); #1;
        send(32'h7F800001, 8'h04, {32'h7FC00000, 5'b10000});
        wait_drain();
        chk("fflags_nv", fflags, 5'b10000);
        @(posedge clk); #1;
        send(32'hFF800001, 8'h10, {32'h7FC00000, 5'b00100});
        send(32'h7F800000, 8'h20, {32'h7F800000, 5'b00001});
        send(32'h00000000, 8'h08, {32'h00000000, 5'b00000});
        send(32'h80000000, 8'hC3, {32'h80000000, 5'b00000});
        wait_drain();
        chk("fflags_accum", fflags, 5'b10101);

        // Clear without pop
        @(posedge clk); #1 fflags_clr = 1'b1;
        @(posedge clk); #1 fflags_clr = 1'b0;
        @(negedge clk);
        chk("fflags_clr", fflags, 0);

        // Clear and pop in the same cycle
        @(posedge clk); #1;
        send(32'h7F800001, 8'h04, {32'h7FC00000, 5'b10000});
        wait_drain();
        chk("fflags_pre_clr", fflags, 5'b10000);
        @(posedge clk); #1 out_ready = 1'b0;
        send(32'h3F800000, 8'h28, {32'h3F800000, 5'b00011});
        out_ready  = 1'b1;
        fflags_clr = 1'b1;
        @(posedge clk); #1 fflags_clr = 1'b0;
        @(negedge clk);
        chk("fflags_clr_pop", fflags, 5'b00011);

        // Fill to two, third held off until a pop
        @(posedge clk); #1 out_ready = 1'b0;
        send(32'h40000000, 8'h00, {32'h40000000, 5'b00000});
        send(32'h40800000, 8'h20, {32'h40800000, 5'b00001});
        @(negedge clk);
        chk("full_count", count, 2);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_z = 32'h40A00000; in_status = 8'h10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("full_hold_count", count, 2);
        @(posedge clk); #1 out_ready = 1'b1;
        send(32'h40A00000, 8'h10, {32'h40A00000, 5'b00100});
        wait_drain();

        // Reset asserted mid-cycle with two entries buffered
        @(posedge clk); #1 out_ready = 1'b0;
        send(32'h41000000, 8'h04, {32'h41000000, 5'b10000});
        send(32'h41100000, 8'h04, {32'h41100000, 5'b10000});
        @(negedge clk);
        chk("pre_rst_count", count, 2);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_fflags", fflags, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        sb.delete();
        @(posedge clk); #1 reset = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale", {out_valid, out_z}, 0);
        end

        // Long stream with random producer gaps and consumer backpressure
        @(posedge clk); #1 fflags_clr = 1'b1;
        @(posedge clk); #1 fflags_clr = 1'b0;
        acc_ff = '0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    logic [31:0] z;
                    logic [7:0]  st;
                    z  = $urandom;
                    st = 8'($urandom);
                    if (i % 5 == 0) z[30:23] = 8'hFF;
                    if (i % 10 == 0) z[22:0] = 23'd0;
                    send(z, st, model(z, st));
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    @(posedge clk); #1 out_ready = 1'($urandom_range(1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        chk("stream_fflags", fflags, acc_ff);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/r5fp_mul_wb.md
R5FP_MUL_WB -- requirements
Module: r5fp_mul_wb

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width of the result word.
REQ-002 SHALL have parameter SIG_W, default 23, stored significand width of the result word.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port in_valid  input  1  multiplier result valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a result this cycle.
REQ-007 SHALL have port in_z  input  EXP_W+SIG_W+1  packed {sign,exp,sig} result from the multiply/postproc stage.
REQ-008 SHALL have port in_status  input  8  postproc status: [0] zero, [1] inf, [2] invalid, [3] tiny, [4] huge, [5] inexact, [7:6] ignored.
REQ-009 SHALL have port out_valid  output  1  writeback entry available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts entry.
REQ-011 SHALL have port out_z  output  EXP_W+SIG_W+1  result word, NaN-canonicalised.
REQ-012 SHALL have port out_flags  output  5  per-result flags {NV,DZ,OF,UF,NX}.
REQ-013 SHALL have port fflags  output  5  sticky accumulated flags, same bit order.
REQ-014 SHALL have port fflags_clr  input  1  synchronous clear of fflags.
REQ-015 SHALL have port count  output  2  FIFO occupancy 0..2.

Function
REQ-016 SHALL buffer results in a 2-entry FIFO (write ptr, read ptr, count); no combinational path in->out.
REQ-017 SHALL drive in_ready = (count != 2), from registered count only.
REQ-018 SHALL push {in_z, flags} when in_valid && in_ready; pop when out_valid && out_ready.
REQ-019 SHALL drive out_valid = (count != 0); minimum latency push-to-out_valid 1 cycle.
REQ-020 SHALL, on simultaneous push and pop with count==1, keep count at 1 and present the pushed entry next cycle.
REQ-021 SHALL never push while count==2 (in_ready low), even if out_ready is high that cycle.
REQ-022 SHALL hold out_z/out_flags stable while out_valid && !out_ready.
REQ-023 SHALL wrap pointers modulo 2.
REQ-024 SHALL map flags at push: NV=status[2], DZ=0, OF=status[4], UF=status[3]&status[5], NX=status[5].
REQ-025 SHALL canonicalise at push: exp all-ones and sig!=0 -> stored word {0, all-ones, 1'b1, zeros} (0x7FC00000 for defaults); other words unchanged.
REQ-026 SHALL update fflags on pop: fflags <= (fflags_clr ? 0 : fflags) | popped out_flags.
REQ-027 SHALL, with fflags_clr and no pop, set fflags to 0 next cycle.
REQ-028 SHALL accumulate at pop (retirement), not at push; discarded-by-reset entries never reach fflags.

Reset
REQ-029 SHALL on reset low immediately clear count, pointers, fflags; out_valid=0, in_ready=0 while reset low.
REQ-030 SHALL drive in_ready=1 first cycle after reset release; out_z, out_flags SHALL read 0 after reset.
REQ-031 SHALL discard buffered entries when reset asserts mid-operation.

Verification
REQ-032 Push 0x40400000, status 0x00, out_ready=1 -> next cycle out_valid=1, out_z=0x40400000, out_flags=0, then count=0.
REQ-033 Push 0x7F800001 status 0x04 -> out_z=0x7FC00000, out_flags=5'b10000; after pop fflags=5'b10000.
REQ-034 out_ready=0, push 3 back-to-back -> first two accepted, count=2, in_ready=0 on third; third held by source, accepted after one pop; order preserved.
REQ-035 Status 0x28 (tiny+inexact) popped same cycle as fflags_clr with prior fflags=5'b10000 -> fflags=5'b00011.
REQ-036 count=2, reset pulse low mid-cycle -> out_valid=0, count=0, fflags=0 immediately; no stale entry appears after release.
REQ-037 count=1, push and pop same cycle, random out_ready over 10k results -> output stream equals input stream, scoreboard exact.
